// File: rtl/product_accumulator.sv
// Saturating multiply-accumulate stage: sums TERMS unsigned 8-bit products
// taken over a valid/ready handshake and strobes the result for one cycle.
module product_accumulator #(
  parameter int ACC_W = 12,
  parameter int TERMS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       product_low_i,
  input  logic [3:0]       product_high_i,
  output logic [ACC_W-1:0] acc_o,
  output logic             acc_valid_o,
  output logic             overflow_o,
  output logic             busy_o,
  output logic [3:0]       term_count_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0]       LAST    = 4'(TERMS - 1);
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [3:0]       cnt_q, cnt_d;

  logic [7:0]       prod;
  logic [ACC_W:0]   prod_ext;
  logic [ACC_W:0]   sum;

  assign prod     = {product_high_i, product_low_i};
  assign prod_ext = {{(ACC_W - 7){1'b0}}, prod};
  // One guard bit suffices: acc <= 2^ACC_W-1 and p <= 255 < 2^ACC_W.
  assign sum      = {1'b0, acc_q} + prod_ext;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = ACCUM;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      ACCUM: begin
        if (in_valid_i) begin
          if (sum[ACC_W]) begin
            acc_d = ACC_MAX;
            ovf_d = 1'b1;
          end else begin
            acc_d = sum[ACC_W-1:0];
          end
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LAST) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake and strobe come from the registered state only.
  assign in_ready_o   = (state_q == ACCUM);
  assign acc_valid_o  = (state_q == DONE);
  assign busy_o       = (state_q != IDLE);
  assign acc_o        = acc_q;
  assign overflow_o   = ovf_q;
  assign term_count_o = cnt_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboarded bench: three instances (defaults, ACC_W=8, TERMS=1) driven by
// directed products; a monitor checks every acc_valid strobe against a queue.
module tb_product_accumulator;

  typedef struct {
    int id;
    int acc;
    int ovf;
    int tc;
  } exp_t;

  logic clk;
  logic       rst_a   [3];
  logic       start_a [3];
  logic       vld_a   [3];
  logic [3:0] ph_a    [3];
  logic [3:0] pl_a    [3];
  logic       rdy_a   [3];
  logic       av_a    [3];
  logic       ovf_a   [3];
  logic       busy_a  [3];
  logic [3:0] tc_a    [3];
  logic [15:0] acc_a  [3];
  logic [11:0] acc0;
  logic [7:0]  acc1;
  logic [11:0] acc2;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  assign acc_a[0] = {4'h0, acc0};
  assign acc_a[1] = {8'h0, acc1};
  assign acc_a[2] = {4'h0, acc2};

  product_accumulator u_def (
    .clk(clk), .rst_n(rst_a[0]), .start_i(start_a[0]), .in_valid_i(vld_a[0]),
    .in_ready_o(rdy_a[0]), .product_low_i(pl_a[0]), .product_high_i(ph_a[0]),
    .acc_o(acc0), .acc_valid_o(av_a[0]), .overflow_o(ovf_a[0]),
    .busy_o(busy_a[0]), .term_count_o(tc_a[0]));

  product_accumulator #(.ACC_W(8)) u_w8 (
    .clk(clk), .rst_n(rst_a[1]), .start_i(start_a[1]), .in_valid_i(vld_a[1]),
    .in_ready_o(rdy_a[1]), .product_low_i(pl_a[1]), .product_high_i(ph_a[1]),
    .acc_o(acc1), .acc_valid_o(av_a[1]), .overflow_o(ovf_a[1]),
    .busy_o(busy_a[1]), .term_count_o(tc_a[1]));

  product_accumulator #(.TERMS(1)) u_t1 (
    .clk(clk), .rst_n(rst_a[2]), .start_i(start_a[2]), .in_valid_i(vld_a[2]),
    .in_ready_o(rdy_a[2]), .product_low_i(pl_a[2]), .product_high_i(ph_a[2]),
    .acc_o(acc2), .acc_valid_o(av_a[2]), .overflow_o(ovf_a[2]),
    .busy_o(busy_a[2]), .term_count_o(tc_a[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int id, input int acc, input int ovf, input int tc);
    exp_t e;
    e.id = id; e.acc = acc; e.ovf = ovf; e.tc = tc;
    sb.push_back(e);
  endtask

  task automatic do_start(input int d);
    start_a[d] = 1'b1;
    tick();
    start_a[d] = 1'b0;
  endtask

  // Optional stall cycles first (in_ready must stay high), then one transfer.
  task automatic feed(input int d, input logic [7:0] p, input int stalls);
    for (int s = 0; s < stalls; s++) begin
      vld_a[d] = 1'b0;
      tick();
      chk("in_ready_stall", 32'(rdy_a[d]), 1);
    end
    vld_a[d] = 1'b1;
    ph_a[d]  = p[7:4];
    pl_a[d]  = p[3:0];
    tick();
    vld_a[d] = 1'b0;
  endtask

  // Scoreboard monitor: every strobe must match the oldest expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (av_a[d] === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_acc_valid: dut %0d strobed with empty scoreboard at %0t", d, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_dut_id", 32'(d), 32'(e.id));
          chk("sb_acc", 32'(acc_a[d]), 32'(e.acc));
          chk("sb_overflow", 32'(ovf_a[d]), 32'(e.ovf));
          chk("sb_term_count", 32'(tc_a[d]), 32'(e.tc));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_a[d] = 1'b0; start_a[d] = 1'b0; vld_a[d] = 1'b0;
      ph_a[d] = 4'h0; pl_a[d] = 4'h0;
    end
    tick(); tick();
    chk("rst_acc", 32'(acc_a[0]), 0);
    chk("rst_acc_valid", 32'(av_a[0]), 0);
    chk("rst_overflow", 32'(ovf_a[0]), 0);
    chk("rst_in_ready", 32'(rdy_a[0]), 0);
    chk("rst_busy", 32'(busy_a[0]), 0);
    chk("rst_term_count", 32'(tc_a[0]), 0);
    for (int d = 0; d < 3; d++) rst_a[d] = 1'b1;
    tick();

    // Four back-to-back products: 6+25+18+36 = 85.
    do_start(0);
    chk("t1_in_ready", 32'(rdy_a[0]), 1);
    chk("t1_busy", 32'(busy_a[0]), 1);
    push(0, 85, 0, 4);
    feed(0, 8'h06, 0); feed(0, 8'h19, 0); feed(0, 8'h12, 0); feed(0, 8'h24, 0);
    chk("t1_acc_valid", 32'(av_a[0]), 1);
    chk("t1_in_ready_done", 32'(rdy_a[0]), 0);
    tick();
    chk("t1_acc_valid_drop", 32'(av_a[0]), 0);
    chk("t1_busy_idle", 32'(busy_a[0]), 0);
    chk("t1_acc_hold", 32'(acc_a[0]), 85);

    // 0xE1 four times with 3 stall cycles between terms: 4*225 = 900.
    do_start(0);
    push(0, 900, 0, 4);
    feed(0, 8'hE1, 0); feed(0, 8'hE1, 3); feed(0, 8'hE1, 3); feed(0, 8'hE1, 3);
    chk("t2_acc_valid", 32'(av_a[0]), 1);
    tick();
    tick();

    // Second start during ACCUM is ignored.
    do_start(0);
    push(0, 85, 0, 4);
    feed(0, 8'h06, 0); feed(0, 8'h19, 0);
    chk("t4_term_count2", 32'(tc_a[0]), 2);
    chk("t4_acc31", 32'(acc_a[0]), 31);
    start_a[0] = 1'b1;
    feed(0, 8'h12, 0);
    start_a[0] = 1'b0;
    chk("t4_term_count3", 32'(tc_a[0]), 3);
    feed(0, 8'h24, 0);
    chk("t4_term_count4", 32'(tc_a[0]), 4);
    tick();
    tick();

    // Async reset mid-accumulation, then a fresh 1+1+1+1 run.
    do_start(0);
    feed(0, 8'h01, 0); feed(0, 8'h01, 0);
    #2 rst_a[0] = 1'b0;
    #1;
    chk("t5_async_acc", 32'(acc_a[0]), 0);
    chk("t5_async_tc", 32'(tc_a[0]), 0);
    chk("t5_async_busy", 32'(busy_a[0]), 0);
    chk("t5_async_ready", 32'(rdy_a[0]), 0);
    tick(); tick();
    rst_a[0] = 1'b1;
    tick();
    do_start(0);
    push(0, 4, 0, 4);
    feed(0, 8'h01, 0); feed(0, 8'h01, 0); feed(0, 8'h01, 0); feed(0, 8'h01, 0);
    tick();
    tick();

    // ACC_W=8 saturation and sticky overflow.
    do_start(1);
    push(1, 255, 1, 4);
    feed(1, 8'hE1, 0);
    chk("t3_acc225", 32'(acc_a[1]), 225);
    chk("t3_no_ovf_yet", 32'(ovf_a[1]), 0);
    feed(1, 8'hE1, 0);
    chk("t3_sat", 32'(acc_a[1]), 255);
    chk("t3_ovf", 32'(ovf_a[1]), 1);
    feed(1, 8'h01, 0);
    chk("t3_sat_hold", 32'(acc_a[1]), 255);
    feed(1, 8'h00, 0);
    tick();
    chk("t3_ovf_idle", 32'(ovf_a[1]), 1);
    chk("t3_acc_idle", 32'(acc_a[1]), 255);
    do_start(1);
    chk("t3_restart_acc", 32'(acc_a[1]), 0);
    chk("t3_restart_ovf", 32'(ovf_a[1]), 0);

    // TERMS=1: busy for exactly two cycles.
    do_start(2);
    chk("t6_busy1", 32'(busy_a[2]), 1);
    push(2, 36, 0, 1);
    feed(2, 8'h24, 0);
    chk("t6_busy2", 32'(busy_a[2]), 1);
    chk("t6_acc_valid", 32'(av_a[2]), 1);
    tick();
    chk("t6_busy_off", 32'(busy_a[2]), 0);
    tick();

    chk("sb_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Sequential stage directly downstream of the 4-bit combinational multiplier in the ALU datapath. It consumes the 8-bit product presented as `product_high`/`product_low` over a valid/ready handshake and sums a fixed number of products into a saturating accumulator. It reports the result with a one-cycle `acc_valid` strobe and a sticky overflow flag, giving the ALU a multiply-accumulate (dot-product) path.

## Interface
- `ACC_W`, default 12: accumulator width in bits; legal range 8..16.
- `TERMS`, default 4: products summed per accumulation; legal range 1..15.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a new accumulation; honoured only in IDLE.
- `in_valid`  in  1  the upstream product on `product_high`/`product_low` is valid this cycle.
- `in_ready`  out  1  block accepts a product this cycle; high only in ACCUM.
- `product_low`  in  4  product bits [3:0] from the multiplier.
- `product_high`  in  4  product bits [7:4] from the multiplier.
- `acc`  out  ACC_W  accumulated sum, registered.
- `acc_valid`  out  1  one-cycle strobe: `acc` holds the final sum.
- `overflow`  out  1  sticky flag: saturation occurred in the current accumulation.
- `busy`  out  1  high in ACCUM and DONE.
- `term_count`  out  4  products accepted so far in the current accumulation.

## Operation
- One clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- Operand: `p = {product_high, product_low}`, unsigned 8 bits, zero-extended to ACC_W+1 bits for the add.
- FSM states are IDLE, ACCUM and DONE; the state is registered.
- IDLE:
  - `in_ready`=0.
  - `start`=1 → ACCUM; clear `acc`, `term_count` and `overflow`.
- ACCUM:
  - `in_ready`=1. A transfer occurs on any edge where `in_valid && in_ready`.
  - On a transfer: `sum = acc + p`. If `sum > 2^ACC_W-1`, load `acc` with 2^ACC_W-1 and set `overflow`=1. Otherwise `acc` = `sum`.
  - On a transfer: `term_count` increments.
  - On the transfer where `term_count == TERMS-1` → DONE.
  - `in_valid`=0 stalls the block indefinitely with no state change.
  - `start` is ignored.
- DONE:
  - Lasts exactly one cycle; `acc_valid`=1, `in_ready`=0, then → IDLE.
  - `start` is ignored.
- In IDLE, `acc`, `overflow` and `term_count` hold their final values until the next `start`.
- Once saturated, `acc` stays at its maximum for the rest of the accumulation. Saturation never wraps.
- `busy` = (state != IDLE).

## Timing
- Reset (async assert): state=IDLE, `acc`=0, `acc_valid`=0, `overflow`=0, `in_ready`=0, `busy`=0, `term_count`=0.
- Reset deassertion is synchronised externally. Reset asserted mid-accumulation aborts it immediately, with no `acc_valid`.
- `in_ready` and `acc_valid` are decoded from the registered state only. They have no combinational path from inputs.
- `start` sampled at edge N → ACCUM from cycle N+1. The first transfer is possible at edge N+1.
- The final transfer at edge M → `acc_valid`=1 during cycle M+1 → IDLE at M+2.
- The earliest re-`start` is sampled at edge M+2.
- Minimum accumulation length is TERMS+2 cycles, with zero stalls.
- `product_*` must be stable only at edges where `in_valid && in_ready`. The multiplier is combinational, so the product is valid in the same cycle as the operands.
- TERMS=1: one transfer → DONE.

## Test plan
- Defaults. Reset, pulse `start`, then feed four back-to-back products: 2×3=0x06, 5×5=0x19, 6×3=0x12, 9×4=0x24 → `acc_valid` one cycle after the 4th transfer, `acc`=85 (0x055), `overflow`=0, `term_count`=4.
- Defaults. Feed 15×15=0xE1 four times, inserting 3 idle `in_valid`=0 cycles between terms → `acc`=900 (0x384). `acc_valid` pulses exactly once, 1 cycle after the last transfer. `in_ready` stays high throughout the stalls.
- ACC_W=8. Feed 0xE1, 0xE1, 0x01, 0x00 → `acc`=255 after the 2nd transfer and remains 255. `overflow`=1 and stays set in IDLE. A new `start` clears `overflow` and `acc` to 0.
- Defaults. Pulse `start` again during ACCUM after 2 terms (6 and 25) → ignored: `term_count` continues 2→3→4. Final `acc` = 31 plus the remaining terms, unaffected by the second `start`.
- Defaults. Pull `rst_n` low mid-cycle after 2 transfers → outputs reach their reset values immediately (asynchronously, before the next edge). No `acc_valid`. After release, a fresh run with 1,1,1,1 → `acc`=4.
- TERMS=1. `start`, then one product 0x24 → `acc`=36, `acc_valid` on the next cycle, `busy` high for exactly 2 cycles after `start` is accepted.
